mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//   Two-master to one-slave request arbiter between the I-cache/D-cache refill ports and the AXI interface port.
//   Replaces the combinational sel_i mux with a registered grant FSM:
//   - latches the winner's request at grant time;
//   - holds the memory side stable until mem_ready;
//   - routes the ready pulse back to the winning cache.
//   Applies round-robin on contention so neither cache starves.
// PARAMETERS
//   ADDR_W  32  address width of cache and memory ports
//   DATA_W  32  data width of read/write data
//   D_FIRST 1   winner when both strobe in IDLE with no history (1: D-cache, 0: I-cache)
// PORTS
//   aclk        in   1       clock, all state updates on rising edge
//   aresetn     in   1       asynchronous active-low reset
//   i_a         in   ADDR_W  I-cache refill address
//   i_strobe    in   1       I-cache refill request, level, held until i_ready
//   i_ready     out  1       one-cycle pulse: I-side transfer done, i_data valid
//   i_data      out  DATA_W  read data to I-cache
//   d_a         in   ADDR_W  D-cache address
//   d_strobe    in   1       D-cache request, level, held until d_ready
//   d_rw        in   1       0 read, 1 write
//   d_size      in   2       0 byte, 1 half, 2 word
//   d_sel       in   4       byte strobes for writes
//   d_wdata     in   DATA_W  D-cache store data
//   d_ready     out  1       one-cycle pulse: D-side transfer done, d_data valid on reads
//   d_data      out  DATA_W  read data to D-cache
//   mem_a       out  ADDR_W  latched address to AXI interface
//   mem_access  out  1       request valid to AXI interface
//   mem_write   out  1       latched write flag
//   mem_size    out  2       latched size; I-side grant forces 2'b10
//   mem_sel     out  4       latched strobes; I-side grant forces 4'b1111
//   mem_st_data out  DATA_W  latched store data
//   mem_ready   in   1       one-cycle pulse from AXI interface: transfer complete
//   mem_data    in   DATA_W  read data from AXI interface, valid with mem_ready
// BEHAVIOUR
//   FSM states: IDLE, GNT_I, GNT_D. Reset state IDLE.
//     last_d (last grant was D) resets to ~D_FIRST.
//   Reset values: all request registers 0; mem_access=0, i_ready=0, d_ready=0.
//     mem_a, mem_st_data, mem_size and mem_sel are 0.
//   IDLE:
//     - only i_strobe -> GNT_I;
//     - only d_strobe -> GNT_D;
//     - both -> grant the side not granted last (last_d ? GNT_I : GNT_D);
//     - neither -> stay in IDLE.
//   On the grant edge, latch the winner's a/rw/size/sel/wdata into mem_* registers.
//     I-side latch uses write=0, size=2'b10, sel=4'b1111.
//     Update last_d on the same edge.
//   GNT_x:
//     - mem_access=1 (combinational from state, registered address);
//     - stay until mem_ready=1;
//     - on that cycle pulse x_ready=1 combinationally;
//     - next state IDLE, mem_access drops.
//   Latency: strobe seen in IDLE at edge N -> mem_access high in cycle N+1.
//     After ready, minimum 1 IDLE cycle before the next grant (bubble).
//   i_data = d_data = mem_data (pass-through); only the granted side's ready pulses.
//   Strobe dropped mid-grant (e.g. pipeline flush): grant still holds until mem_ready.
//     The memory transaction is in flight and is not aborted.
//     Ready still pulses to that side; the cache ignores it. Latched fields never change mid-grant.
//   Strobe inputs changing while granted are ignored until return to IDLE.
//   mem_ready while in IDLE is ignored; no ready pulse to either side.
//   Reset asserted mid-grant: immediate return to IDLE, all outputs to reset values.
//     The AXI interface is reset by the same aresetn.
//   Never mem_access with both sides granted; i_ready & d_ready is never 1.
// TESTING
//   I-side only: i_a=0xBFC00000, i_strobe=1; mem_ready pulses 3 cycles after grant ->
//     mem_access 1 cycle after strobe, mem_size=2, mem_sel=F, mem_write=0, i_ready=1 for exactly one cycle, d_ready=0.
//   D-side write: d_a=0x80001004, d_rw=1, d_size=0, d_sel=4'b0010, d_wdata=0x0000AB00 ->
//     mem fields match latched values, d_ready pulses on mem_ready.
//   Contention after reset (D_FIRST=1): both strobe together -> D granted first, then I after 1 bubble.
//     Repeat contention -> grants alternate I, D, I, D.
//   Flush: D granted, d_strobe dropped and d_a changed to 0x0 mid-grant ->
//     mem_a stays 0x80001004 until mem_ready, d_ready still pulses, then IDLE.
//   Reset mid-grant: aresetn low while GNT_I with mem_access=1 ->
//     mem_access, i_ready, d_ready go 0 immediately; IDLE after release.
//   Spurious mem_ready in IDLE -> no ready pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Cache-refill / memory-side bundle shared by the I-cache, D-cache and AXI interface port.
// Handshake: a cache holds x_strobe (level) until x_ready pulses; mem_access stays high until mem_ready pulses.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] i_a;
    logic              i_strobe;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;

    logic [ADDR_W-1:0] d_a;
    logic              d_strobe;
    logic              d_rw;
    logic [1:0]        d_size;
    logic [3:0]        d_sel;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_data;

    logic [ADDR_W-1:0] mem_a;
    logic              mem_access;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic [3:0]        mem_sel;
    logic [DATA_W-1:0] mem_st_data;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;

    // Arbiter side.
    modport slave (
        input  i_a, i_strobe, d_a, d_strobe, d_rw, d_size, d_sel, d_wdata,
        input  mem_ready, mem_data,
        output i_ready, i_data, d_ready, d_data,
        output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
    );

    // Caches plus AXI interface side.
    modport master (
        output i_a, i_strobe, d_a, d_strobe, d_rw, d_size, d_sel, d_wdata,
        output mem_ready, mem_data,
        input  i_ready, i_data, d_ready, d_data,
        input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave (AXI port) arbiter with a registered grant FSM,
// round-robin on contention, and request fields latched for the whole transaction.
module mem_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit D_FIRST = 1'b1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    mem_req_arbiter_if.slave       bus,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0] mem_st_data_q, mem_st_data_d;
    logic              win_d;

    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        mem_a_d       = mem_a_q;
        mem_write_d   = mem_write_q;
        mem_size_d    = mem_size_q;
        mem_sel_d     = mem_sel_q;
        mem_st_data_d = mem_st_data_q;
        win_d         = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the side that did not win last time goes first.
                if (bus.i_strobe && bus.d_strobe) win_d = ~last_d_q;
                else                              win_d = bus.d_strobe;

                if (bus.i_strobe || bus.d_strobe) begin
                    last_d_d = win_d;
                    if (win_d) begin
                        state_d       = GNT_D;
                        mem_a_d       = bus.d_a;
                        mem_write_d   = bus.d_rw;
                        mem_size_d    = bus.d_size;
                        mem_sel_d     = bus.d_sel;
                        mem_st_data_d = bus.d_wdata;
                    end else begin
                        state_d       = GNT_I;
                        mem_a_d       = bus.i_a;
                        mem_write_d   = 1'b0;
                        mem_size_d    = 2'b10;
                        mem_sel_d     = 4'b1111;
                        mem_st_data_d = '0;
                    end
                end
            end
            // Strobes are deliberately not looked at here: an in-flight transfer is never aborted.
            GNT_I, GNT_D: begin
                if (bus.mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            last_d_q      <= ~D_FIRST;
            mem_a_q       <= '0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= 2'b00;
            mem_sel_q     <= 4'b0000;
            mem_st_data_q <= '0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            mem_a_q       <= mem_a_d;
            mem_write_q   <= mem_write_d;
            mem_size_q    <= mem_size_d;
            mem_sel_q     <= mem_sel_d;
            mem_st_data_q <= mem_st_data_d;
        end
    end

    assign bus.mem_access  = (state_q == GNT_I) || (state_q == GNT_D);
    assign bus.mem_a       = mem_a_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_size    = mem_size_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_st_data = mem_st_data_q;

    assign bus.i_ready = (state_q == GNT_I) && bus.mem_ready;
    assign bus.d_ready = (state_q == GNT_D) && bus.mem_ready;
    assign bus.i_data  = bus.mem_data;
    assign bus.d_data  = bus.mem_data;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a round-robin request model.
module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] dbg_state;

    always #5 aclk = ~aclk;

    mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_FIRST(1'b1)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          is;
        logic          ds;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic          rw;
        logic [1:0]    size;
        logic [3:0]    sel;
        logic [DW-1:0] wd;
        int            lat;
        logic          exp_d;
        logic [AW-1:0] exp_a;
        logic          exp_w;
        logic [1:0]    exp_size;
        logic [3:0]    exp_sel;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_a = '0; bus.i_strobe = 1'b0;
        bus.d_a = '0; bus.d_strobe = 1'b0; bus.d_rw = 1'b0;
        bus.d_size = 2'b00; bus.d_sel = 4'b0000; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_data = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    // Entered in IDLE with strobes already driven; leaves one cycle after the ready edge.
    task automatic run_grant(input logic exp_d, input logic [AW-1:0] ea, input logic ew,
                             input logic [1:0] es, input logic [3:0] esel,
                             input logic [DW-1:0] ewd, input int lat, input logic flush);
        logic [DW-1:0] rd;
        logic [DW-1:0] want;
        chk("idle_access", 64'(bus.mem_access), 64'(0));
        step();
        chk("grant_access", 64'(bus.mem_access), 64'(1));
        chk("grant_addr", 64'(bus.mem_a), 64'(ea));
        chk("grant_write", 64'(bus.mem_write), 64'(ew));
        chk("grant_size", 64'(bus.mem_size), 64'(es));
        chk("grant_sel", 64'(bus.mem_sel), 64'(esel));
        if (exp_d) chk("grant_wdata", 64'(bus.mem_st_data), 64'(ewd));
        chk("grant_no_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
        if (flush) begin
            if (exp_d) begin
                bus.d_strobe = 1'b0; bus.d_a = '0; bus.d_rw = ~bus.d_rw;
                bus.d_sel = ~bus.d_sel; bus.d_wdata = $urandom;
            end else begin
                bus.i_strobe = 1'b0; bus.i_a = '0;
            end
        end
        for (int k = 0; k < lat; k++) begin
            step();
            chk("hold_access", 64'(bus.mem_access), 64'(1));
            chk("hold_addr", 64'(bus.mem_a), 64'(ea));
            chk("hold_write", 64'(bus.mem_write), 64'(ew));
            chk("hold_no_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
        end
        rd = $urandom;
        exp_q.push_back(rd);
        bus.mem_ready = 1'b1;
        bus.mem_data  = rd;
        #1;
        want = exp_q.pop_front();
        chk("i_ready_pulse", 64'(bus.i_ready), 64'(!exp_d));
        chk("d_ready_pulse", 64'(bus.d_ready), 64'(exp_d));
        chk("ready_addr", 64'(bus.mem_a), 64'(ea));
        chk("read_data", 64'(exp_d ? bus.d_data : bus.i_data), 64'(want));
        step();
        bus.mem_ready = 1'b0;
        if (exp_d) bus.d_strobe = 1'b0;
        else       bus.i_strobe = 1'b0;
        #1;
        chk("bubble_access", 64'(bus.mem_access), 64'(0));
        chk("bubble_no_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
    endtask

    task automatic drive_d(input logic [AW-1:0] a, input logic rw, input logic [1:0] sz,
                           input logic [3:0] sel, input logic [DW-1:0] wd);
        bus.d_strobe = 1'b1; bus.d_a = a; bus.d_rw = rw;
        bus.d_size = sz; bus.d_sel = sel; bus.d_wdata = wd;
    endtask

    initial begin
        logic m_last_d;
        logic i_pend, d_pend, w_d;
        logic [AW-1:0] ea;
        logic ew;
        logic [1:0] es;
        logic [3:0] esel;

        vecs[0] = '{1'b1, 1'b0, 32'hBFC00000, 32'h0, 1'b0, 2'd0, 4'h0, 32'h0, 3,
                    1'b0, 32'hBFC00000, 1'b0, 2'd2, 4'hF};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h80001004, 1'b1, 2'd0, 4'b0010, 32'h0000AB00, 2,
                    1'b1, 32'h80001004, 1'b1, 2'd0, 4'b0010};
        vecs[2] = '{1'b1, 1'b1, 32'h00001000, 32'h00002000, 1'b0, 2'd2, 4'hF, 32'h0, 1,
                    1'b1, 32'h00002000, 1'b0, 2'd2, 4'hF};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h00000030, 1'b0, 2'd1, 4'b0011, 32'h0, 0,
                    1'b1, 32'h00000030, 1'b0, 2'd1, 4'b0011};
        vecs[4] = '{1'b1, 1'b0, 32'h00000004, 32'h0, 1'b0, 2'd0, 4'h0, 32'h0, 0,
                    1'b0, 32'h00000004, 1'b0, 2'd2, 4'hF};

        clear_inputs();
        do_reset();
        chk("reset_state", 64'(dbg_state), 64'(0));
        chk("reset_access", 64'(bus.mem_access), 64'(0));
        chk("reset_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
        chk("reset_fields", 64'({bus.mem_a, bus.mem_size, bus.mem_sel, bus.mem_write}), 64'(0));
        chk("reset_wdata", 64'(bus.mem_st_data), 64'(0));

        // Directed vector table, each from a fresh reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.i_strobe = vecs[v].is; bus.i_a = vecs[v].ia;
            if (vecs[v].ds) drive_d(vecs[v].da, vecs[v].rw, vecs[v].size, vecs[v].sel, vecs[v].wd);
            run_grant(vecs[v].exp_d, vecs[v].exp_a, vecs[v].exp_w, vecs[v].exp_size,
                      vecs[v].exp_sel, vecs[v].wd, vecs[v].lat, 1'b0);
        end

        // Contention: D first after reset, then strict alternation I, D, I, D.
        do_reset();
        bus.i_strobe = 1'b1; bus.i_a = 32'h00000100;
        drive_d(32'h00000200, 1'b0, 2'd2, 4'hF, 32'h0);
        run_grant(1'b1, 32'h00000200, 1'b0, 2'd2, 4'hF, 32'h0, 1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) drive_d(32'h00000200 + 32'(r), 1'b0, 2'd2, 4'hF, 32'h0);
            else begin bus.i_strobe = 1'b1; bus.i_a = 32'h00000100 + 32'(r); end
            if (r % 2 == 0) run_grant(1'b0, bus.i_a, 1'b0, 2'd2, 4'hF, 32'h0, 1, 1'b0);
            else run_grant(1'b1, bus.d_a, 1'b0, 2'd2, 4'hF, 32'h0, 1, 1'b0);
        end

        // Flush mid-grant: latched fields survive, ready still pulses.
        do_reset();
        drive_d(32'h80001004, 1'b1, 2'd0, 4'b0010, 32'h0000AB00);
        run_grant(1'b1, 32'h80001004, 1'b1, 2'd0, 4'b0010, 32'h0000AB00, 3, 1'b1);
        chk("flush_idle_state", 64'(dbg_state), 64'(0));

        // Reset asserted mid-grant.
        do_reset();
        bus.i_strobe = 1'b1; bus.i_a = 32'hBFC00000;
        step();
        chk("rst_pre_access", 64'(bus.mem_access), 64'(1));
        bus.mem_ready = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_access", 64'(bus.mem_access), 64'(0));
        chk("rst_mid_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
        chk("rst_mid_addr", 64'(bus.mem_a), 64'(0));
        bus.mem_ready = 1'b0; bus.i_strobe = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        chk("rst_after_state", 64'(dbg_state), 64'(0));
        chk("rst_after_access", 64'(bus.mem_access), 64'(0));

        // Spurious mem_ready in IDLE.
        bus.mem_ready = 1'b1; bus.mem_data = 32'hDEADBEEF;
        #1;
        chk("spur_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
        step();
        bus.mem_ready = 1'b0;
        #1;
        chk("spur_state", 64'(dbg_state), 64'(0));
        chk("spur_access", 64'(bus.mem_access), 64'(0));

        // Randomized traffic against a round-robin model with pending-request flags.
        do_reset();
        m_last_d = 1'b0;
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!i_pend && ($urandom % 2 == 0)) begin
                i_pend = 1'b1; bus.i_strobe = 1'b1; bus.i_a = $urandom;
            end
            if (!d_pend && ($urandom % 2 == 0)) begin
                d_pend = 1'b1;
                drive_d($urandom, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom), $urandom);
            end
            if (!i_pend && !d_pend) begin
                bus.mem_ready = 1'($urandom);
                #1;
                chk("rnd_idle_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
                step();
                bus.mem_ready = 1'b0;
                #1;
                chk("rnd_idle_access", 64'(bus.mem_access), 64'(0));
                continue;
            end
            w_d = (i_pend && d_pend) ? !m_last_d : d_pend;
            m_last_d = w_d;
            if (w_d) begin
                ea = bus.d_a; ew = bus.d_rw; es = bus.d_size; esel = bus.d_sel;
            end else begin
                ea = bus.i_a; ew = 1'b0; es = 2'd2; esel = 4'hF;
            end
            run_grant(w_d, ea, ew, es, esel, bus.d_wdata, int'($urandom_range(0, 3)),
                      1'($urandom % 4 == 0));
            if (w_d) d_pend = 1'b0;
            else     i_pend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
